// File: rtl/distribute_1xn_one_hot_bp_seq_pkg.sv
// Shared definitions for the 1xN one-hot distribute hop: port indexing and
// the derived width of the command forwarded to the next hop.
package distribute_1xn_one_hot_bp_seq_pkg;

  localparam int BUS_PORT   = 0;
  localparam int LOCAL_BASE = 1;

  // Command bits left for downstream hops, never narrower than one bit.
  function automatic int out_cmd_width(input int in_w, input int num_local);
    if (in_w - num_local > 1) begin
      return in_w - num_local;
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/distribute_hold_slot.sv
// Single-entry holding slot: payload, per-output pending mask and forwarded
// command. Pending bits clear individually as their outputs hand off.
module distribute_hold_slot #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 3,
  parameter int CMD_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic [NUM_PORTS-1:0]  load_pend_i,
  input  logic [CMD_WIDTH-1:0]  load_cmd_i,
  input  logic [NUM_PORTS-1:0]  xfer_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [NUM_PORTS-1:0]  pend_o,
  output logic [CMD_WIDTH-1:0]  cmd_o
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_PORTS-1:0]  pend_q, pend_d;
  logic [CMD_WIDTH-1:0]  cmd_q,  cmd_d;

  // Next state: a load only happens once every pending port has drained.
  always_comb begin
    data_d = data_q;
    pend_d = pend_q & ~xfer_i;
    cmd_d  = cmd_q;
    if (load_i) begin
      data_d = load_data_i;
      pend_d = load_pend_i;
      cmd_d  = load_cmd_i;
    end else begin
      data_d = data_q;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      pend_q <= '0;
      cmd_q  <= '0;
    end else begin
      data_q <= data_d;
      pend_q <= pend_d;
      cmd_q  <= cmd_d;
    end
  end

  assign data_o = data_q;
  assign pend_o = pend_q;
  assign cmd_o  = cmd_q;

endmodule

// File: rtl/distribute_1xn_one_hot_bp_seq.sv
// One hop of a chained distribution network: multicasts each word to the
// local ports named by the low command bits and forwards the rest on the bus.
module distribute_1xn_one_hot_bp_seq
  import distribute_1xn_one_hot_bp_seq_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int NUM_LOCAL          = 2,
  parameter int IN_COMMAND_WIDTH   = 8,
  parameter int PASS_PRUNE         = 0,
  localparam int OUT_COMMAND_WIDTH = out_cmd_width(IN_COMMAND_WIDTH, NUM_LOCAL),
  localparam int NUM_PORTS         = NUM_LOCAL + 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_valid,
  output logic                            i_ready,
  input  logic [DATA_WIDTH-1:0]           i_data_bus,
  input  logic                            i_en,
  input  logic [IN_COMMAND_WIDTH-1:0]     i_cmd,
  output logic [NUM_PORTS-1:0]            o_valid,
  input  logic [NUM_PORTS-1:0]            o_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] o_data_bus,
  output logic [OUT_COMMAND_WIDTH-1:0]    o_cmd,
  output logic                            o_busy
);

  logic [DATA_WIDTH-1:0]        data_q;
  logic [NUM_PORTS-1:0]         pend_q;
  logic [OUT_COMMAND_WIDTH-1:0] cmd_q;
  logic [NUM_PORTS-1:0]         xfer_s;
  logic [NUM_PORTS-1:0]         pend_load_s;
  logic [OUT_COMMAND_WIDTH-1:0] cmd_load_s;
  logic                         drain_done_s;
  logic                         accept_s;

  assign xfer_s       = pend_q & o_ready;
  assign drain_done_s = ((pend_q & ~xfer_s) == '0);
  // Ready looks through this cycle's handoffs so the slot can refill with no bubble.
  assign i_ready      = rst_n & i_en & drain_done_s;
  assign accept_s     = i_valid & i_ready;

  // Command decode: local bits select ports, the remainder goes to the next hop.
  always_comb begin
    pend_load_s                        = '0;
    pend_load_s[LOCAL_BASE +: NUM_LOCAL] = i_cmd[NUM_LOCAL-1:0];
    cmd_load_s                         = OUT_COMMAND_WIDTH'(i_cmd >> NUM_LOCAL);
    if (PASS_PRUNE == 0) begin
      pend_load_s[BUS_PORT] = 1'b1;
    end else begin
      pend_load_s[BUS_PORT] = |(i_cmd >> NUM_LOCAL);
    end
  end

  distribute_hold_slot #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_PORTS  (NUM_PORTS),
    .CMD_WIDTH  (OUT_COMMAND_WIDTH)
  ) u_slot (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept_s),
    .load_data_i (i_data_bus),
    .load_pend_i (pend_load_s),
    .load_cmd_i  (cmd_load_s),
    .xfer_i      (xfer_s),
    .data_o      (data_q),
    .pend_o      (pend_q),
    .cmd_o       (cmd_q)
  );

  // Output muxing: ports with nothing pending present an all-zero dummy word.
  always_comb begin
    o_data_bus = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (pend_q[j]) begin
        o_data_bus[j*DATA_WIDTH +: DATA_WIDTH] = data_q;
      end else begin
        o_data_bus[j*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
    if (pend_q[BUS_PORT]) begin
      o_cmd = cmd_q;
    end else begin
      o_cmd = '0;
    end
  end

  assign o_valid = pend_q;
  assign o_busy  = |pend_q;

endmodule

// File: tb/tb_distribute_1xn_one_hot_bp_seq.sv
// Directed scoreboard bench: default hop (A), pruning hop (P) and a hop with
// no command bits left for the bus (W).
module tb_distribute_1xn_one_hot_bp_seq;

  logic clk;
  logic rst_n;

  logic        a_valid, a_ready, a_en, a_busy;
  logic [31:0] a_data;
  logic [7:0]  a_cmd;
  logic [2:0]  a_ovalid, a_oready;
  logic [95:0] a_odata;
  logic [5:0]  a_ocmd;

  logic        p_valid, p_ready, p_en, p_busy;
  logic [31:0] p_data;
  logic [7:0]  p_cmd;
  logic [2:0]  p_ovalid, p_oready;
  logic [95:0] p_odata;
  logic [5:0]  p_ocmd;

  logic        w_valid, w_ready, w_en, w_busy;
  logic [31:0] w_data;
  logic [1:0]  w_cmd;
  logic [2:0]  w_ovalid, w_oready;
  logic [95:0] w_odata;
  logic [0:0]  w_ocmd;

  typedef struct {
    int          inst;
    logic [2:0]  valid;
    logic [95:0] data;
    logic [5:0]  cmd;
    logic        busy;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  distribute_1xn_one_hot_bp_seq #(.DATA_WIDTH(32), .NUM_LOCAL(2), .IN_COMMAND_WIDTH(8), .PASS_PRUNE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_valid(a_valid), .i_ready(a_ready), .i_data_bus(a_data),
    .i_en(a_en), .i_cmd(a_cmd), .o_valid(a_ovalid), .o_ready(a_oready),
    .o_data_bus(a_odata), .o_cmd(a_ocmd), .o_busy(a_busy));

  distribute_1xn_one_hot_bp_seq #(.DATA_WIDTH(32), .NUM_LOCAL(2), .IN_COMMAND_WIDTH(8), .PASS_PRUNE(1)) dut_p (
    .clk(clk), .rst_n(rst_n), .i_valid(p_valid), .i_ready(p_ready), .i_data_bus(p_data),
    .i_en(p_en), .i_cmd(p_cmd), .o_valid(p_ovalid), .o_ready(p_oready),
    .o_data_bus(p_odata), .o_cmd(p_ocmd), .o_busy(p_busy));

  distribute_1xn_one_hot_bp_seq #(.DATA_WIDTH(32), .NUM_LOCAL(2), .IN_COMMAND_WIDTH(2), .PASS_PRUNE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .i_valid(w_valid), .i_ready(w_ready), .i_data_bus(w_data),
    .i_en(w_en), .i_cmd(w_cmd), .o_valid(w_ovalid), .o_ready(w_oready),
    .o_data_bus(w_odata), .o_cmd(w_ocmd), .o_busy(w_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int inst, input logic [2:0] v, input logic [31:0] d, input logic [5:0] c);
    exp_t e;
    e.inst  = inst;
    e.valid = v;
    e.data  = {(v[2] ? d : 32'h0), (v[1] ? d : 32'h0), (v[0] ? d : 32'h0)};
    e.cmd   = v[0] ? c : 6'h0;
    e.busy  = |v;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t        e;
    logic [2:0]  ov;
    logic [95:0] od;
    logic [5:0]  oc;
    logic        ob;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb_q.pop_front();
      case (e.inst)
        0:       begin ov = a_ovalid; od = a_odata; oc = a_ocmd;         ob = a_busy; end
        1:       begin ov = p_ovalid; od = p_odata; oc = p_ocmd;         ob = p_busy; end
        default: begin ov = w_ovalid; od = w_odata; oc = {5'b0, w_ocmd}; ob = w_busy; end
      endcase
      chk({tag, "_valid"}, 128'(ov), 128'(e.valid));
      chk({tag, "_data"},  128'(od), 128'(e.data));
      chk({tag, "_cmd"},   128'(oc), 128'(e.cmd));
      chk({tag, "_busy"},  128'(ob), 128'(e.busy));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_en = 1'b1; a_data = 32'h0; a_cmd = 8'h0; a_oready = 3'b111;
    p_valid = 1'b0; p_en = 1'b1; p_data = 32'h0; p_cmd = 8'h0; p_oready = 3'b111;
    w_valid = 1'b0; w_en = 1'b1; w_data = 32'h0; w_cmd = 2'b00; w_oready = 3'b111;
    #12;
    push(0, 3'b000, 32'h0, 6'h0);
    pop_check("reset");
    chk("reset_iready", 128'(a_ready), 128'(1'b0));
    tick();
    #3 rst_n = 1'b1;

    // Basic multicast and back-to-back streaming.
    a_valid = 1'b1; a_data = 32'hA5A5_0001; a_cmd = 8'b0000_0110;
    #1 chk("empty_iready", 128'(a_ready), 128'(1'b1));
    push(0, 3'b101, 32'hA5A5_0001, 6'b000001);
    tick();
    pop_check("word1");
    a_data = 32'h1111_2222; a_cmd = 8'b0000_0001;
    #1 chk("b2b_iready1", 128'(a_ready), 128'(1'b1));
    push(0, 3'b011, 32'h1111_2222, 6'h0);
    tick();
    pop_check("word2");
    a_data = 32'h3333_4444; a_cmd = 8'b1111_1110;
    #1 chk("b2b_iready2", 128'(a_ready), 128'(1'b1));
    push(0, 3'b101, 32'h3333_4444, 6'h3F);
    tick();
    pop_check("word3");
    a_valid = 1'b0;
    push(0, 3'b000, 32'h0, 6'h0);
    tick();
    pop_check("idle");

    // Partial multicast acceptance, then refill with no bubble.
    a_oready = 3'b001; a_valid = 1'b1; a_data = 32'hCAFE_0003; a_cmd = 8'b0000_0011;
    push(0, 3'b111, 32'hCAFE_0003, 6'h0);
    tick();
    pop_check("pm_load");
    a_data = 32'hBEEF_0004; a_cmd = 8'b0000_0100;
    #1 chk("pm_iready_a", 128'(a_ready), 128'(1'b0));
    push(0, 3'b110, 32'hCAFE_0003, 6'h0);
    tick();
    pop_check("pm_bus_done");
    a_oready = 3'b010;
    #1 chk("pm_iready_b", 128'(a_ready), 128'(1'b0));
    push(0, 3'b100, 32'hCAFE_0003, 6'h0);
    tick();
    pop_check("pm_l0_done");
    a_oready = 3'b100;
    #1 chk("pm_iready_c", 128'(a_ready), 128'(1'b1));
    push(0, 3'b001, 32'hBEEF_0004, 6'b000001);
    tick();
    pop_check("pm_no_bubble");
    a_valid = 1'b0; a_oready = 3'b111;
    push(0, 3'b000, 32'h0, 6'h0);
    tick();
    pop_check("pm_drained");

    // Enable gating blocks acceptance but not draining.
    a_en = 1'b0; a_valid = 1'b1; a_data = 32'h5555_0005; a_cmd = 8'b0000_0010;
    #1 chk("en_off_iready", 128'(a_ready), 128'(1'b0));
    push(0, 3'b000, 32'h0, 6'h0);
    tick();
    pop_check("en_off_noload");
    a_en = 1'b1; a_oready = 3'b000;
    push(0, 3'b101, 32'h5555_0005, 6'h0);
    tick();
    pop_check("en_load");
    a_en = 1'b0; a_valid = 1'b0; a_oready = 3'b111;
    #1 chk("en_off_iready2", 128'(a_ready), 128'(1'b0));
    push(0, 3'b000, 32'h0, 6'h0);
    tick();
    pop_check("en_off_drain");

    // Reset while a word is stuck in the slot.
    a_en = 1'b1; a_oready = 3'b000; a_valid = 1'b1; a_data = 32'hDEAD_0005; a_cmd = 8'b0000_0011;
    push(0, 3'b111, 32'hDEAD_0005, 6'h0);
    tick();
    pop_check("rst_preload");
    a_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    push(0, 3'b000, 32'h0, 6'h0);
    pop_check("rst_mid");
    chk("rst_mid_iready", 128'(a_ready), 128'(1'b0));
    tick();
    #3 rst_n = 1'b1;
    a_oready = 3'b111;
    push(0, 3'b000, 32'h0, 6'h0);
    tick();
    pop_check("rst_no_ghost");

    // Bus pruning.
    p_valid = 1'b1; p_data = 32'h1234_0006; p_cmd = 8'b0000_0001;
    push(1, 3'b010, 32'h1234_0006, 6'h0);
    tick();
    pop_check("prune_local");
    p_data = 32'h1234_0007; p_cmd = 8'b0000_0000;
    #1 chk("prune_empty_iready", 128'(p_ready), 128'(1'b1));
    push(1, 3'b000, 32'h0, 6'h0);
    tick();
    pop_check("prune_drop");
    p_data = 32'h1234_0008; p_cmd = 8'b0000_1000;
    push(1, 3'b001, 32'h1234_0008, 6'b000010);
    tick();
    pop_check("prune_bus");
    p_valid = 1'b0;

    // No command bits left for the next hop.
    w_valid = 1'b1; w_data = 32'h0BAD_0007; w_cmd = 2'b11;
    push(2, 3'b111, 32'h0BAD_0007, 6'h0);
    tick();
    pop_check("width_edge");
    w_valid = 1'b0;
    tick();

    chk("sb_empty", 128'(sb_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/distribute_1xn_one_hot_bp_seq.md
Name: distribute_1xn_one_hot_bp_seq

Overview:
- Parametrised successor of the 1x2 one-hot sequential distribute switch.
- One input stream feeds NUM_LOCAL local node ports plus one pass-through bus port. The local ports multicast by one-hot command bits.
- Adds per-output valid/ready backpressure, a single-entry holding slot with partial-acceptance tracking, and optional pruning of the pass-through port.
- Sits as one hop in a chained distribution network. Each hop consumes the NUM_LOCAL command LSBs.

Parameters:
- DATA_WIDTH, 32, payload width.
- NUM_LOCAL, 2, number of local node outputs (>=1).
- IN_COMMAND_WIDTH, 8, input command width (>=NUM_LOCAL).
- PASS_PRUNE, 0: 0 = always forward on the bus port; 1 = forward only if the shifted command is nonzero.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input data valid.
- i_ready  out  1  switch can accept input this cycle.
- i_data_bus  in  DATA_WIDTH  input payload.
- i_en  in  1  acceptance enable.
- i_cmd  in  IN_COMMAND_WIDTH  one-hot/multi-hot destination tag; bit k selects local port k.
- o_valid  out  NUM_LOCAL+1  per-output valid; bit 0 = bus, bit k+1 = local k.
- o_ready  in  NUM_LOCAL+1  per-output ready, same indexing.
- o_data_bus  out  (NUM_LOCAL+1)*DATA_WIDTH  slice j = output j; slice 0 is the low slice.
- o_cmd  out  OUT_COMMAND_WIDTH  command forwarded on the bus port.
- o_busy  out  1  holding slot occupied.

Behaviour:
- OUT_COMMAND_WIDTH = max(1, IN_COMMAND_WIDTH-NUM_LOCAL). It is computed locally, not overridable.
- Reset (async, rst_n=0):
  - o_valid=0, o_data_bus=0, o_cmd=0, o_busy=0.
  - Slot cleared; any in-flight word is discarded.
  - i_ready=0 while rst_n=0.
- Slot state: data register, pend mask (NUM_LOCAL+1 bits), cmd register.
  - o_valid=pend and o_busy=|pend.
  - o_data_bus slice j = data when pend[j], else all-zero dummy.
  - o_cmd = cmd register when pend[0], else 0.
- Handshakes:
  - Output j transfers when o_valid[j]&&o_ready[j]; pend[j] clears next cycle.
  - Each output transfers independently (partial multicast acceptance). A transferred port never re-sends the same word.
- drain_done = ((pend & ~(o_valid&o_ready)) == 0).
- i_ready = rst_n && i_en && drain_done. This is combinational from o_ready, and single-slot throughput requires it.
- Accept = i_valid && i_ready. On accept the slot loads on the next edge (latency 1 cycle):
  - data <= i_data_bus.
  - pend[k+1] <= i_cmd[k] for k<NUM_LOCAL.
  - cmd <= i_cmd>>NUM_LOCAL, zero-filled and truncated to OUT_COMMAND_WIDTH.
  - pend[0] <= 1 if PASS_PRUNE=0, else pend[0] <= (i_cmd>>NUM_LOCAL)!=0.
- Throughput: 1 word/cycle when all selected outputs are ready.
- Simultaneous drain of the last pending port and accept of a new word: the new word loads with no bubble.
- Empty mask on accept (PASS_PRUNE=1, no local bits, shifted cmd=0): the word is consumed and dropped, and the slot stays empty.
- i_en=0:
  - Blocks new acceptance only.
  - A word already in the slot keeps draining.
- i_valid=0 with the slot empty: outputs stay 0.
- Command width edge: when IN_COMMAND_WIDTH==NUM_LOCAL, o_cmd is the 1-bit constant 0.

Decomposition:
- Shared package: function for out_cmd_width(in_w, num_local) and localparam helpers for port indexing (BUS_PORT=0, LOCAL_BASE=1).
- One natural sub-module, distribute_hold_slot: data/pend/cmd registers with per-bit clear on handshake and load on accept. The top level does command decode, pruning, ready logic and output muxing.

Test Plan:
- Reset mid-operation: slot loaded with pend=3'b111 and o_ready=0, assert rst_n=0 -> o_valid=0, o_data_bus=0, o_busy=0 immediately; after release the old word never appears.
- NUM_LOCAL=2, PASS_PRUNE=0, all o_ready=1:
  - Send data 0xA5A5_0001 with i_cmd=8'b0000_0110.
  - Next cycle: o_valid=3'b101, slice2=0xA5A5_0001, slice1=0, slice0=0xA5A5_0001, o_cmd=6'b000001.
  - Back-to-back words: i_ready stays 1.
- Partial multicast:
  - Send i_cmd=8'b11 with o_ready=3'b001: pend goes to 3'b110 and i_ready=0.
  - Next cycle o_ready=3'b010: pend=3'b100.
  - Next cycle o_ready=3'b100: a new word accepted that same cycle appears the following cycle with no bubble.
- PASS_PRUNE=1:
  - i_cmd=8'b0000_0001 -> o_valid=3'b010 (bus suppressed).
  - i_cmd=8'b0 -> word consumed (i_ready=1), o_valid stays 0, o_busy=0.
- i_en toggling:
  - i_en=0 with i_valid=1 and the slot empty -> i_ready=0, no load.
  - i_en=0 with a word pending -> the word still drains to ready outputs.
- Width edge: IN_COMMAND_WIDTH=NUM_LOCAL=2 and i_cmd=2'b11 -> o_valid=3'b111, o_cmd=1'b0.
